// File: rtl/spi_reg_bank.sv
// spi_reg_bank: register bank behind the SPI slave with command pulses, IRQ mask,
// sticky W1C event flags, generic control registers and saturating write counters.
module spi_reg_bank #(
   parameter int                      NUM_CTRL = 4,
   parameter logic [16*NUM_CTRL-1:0]  CTRL_RST = '0,
   parameter int                      RD_WIDTH = 16*(4+NUM_CTRL)
) (
   input  logic                      reg_clk,
   input  logic                      rst,
   input  logic [7:0]                reg_wr_addr,
   input  logic [15:0]               reg_wr_data,
   input  logic                      reg_wr_en,
   output logic [RD_WIDTH-1:0]       reg_rd_data,
   input  logic [15:0]               evt_i,
   output logic [15:0]               cmd_pulse_o,
   output logic [16*NUM_CTRL-1:0]    ctrl_o,
   output logic                      irq_o
);
   localparam logic [7:0] ADDR_END = 8'(3 + NUM_CTRL);
   logic [15:0] cmd_q, cmd_d, mask_q, mask_d, flags_q, flags_d, evt_q;
   logic [15:0] wr_cnt_q, wr_cnt_d, bad_cnt_q, bad_cnt_d;
   logic [7:0] last_q, last_d;
   logic irq_q, irq_d, armed_q;
   logic [16*NUM_CTRL-1:0] ctrl_q, ctrl_d;
   logic [RD_WIDTH-1:0] rd_q, rd_d;
   logic valid, clr;
   always_comb begin
      valid = reg_wr_addr < ADDR_END;
      clr = reg_wr_en && reg_wr_addr == 8'h00 && reg_wr_data[15];
      cmd_d = (reg_wr_en && reg_wr_addr == 8'h00) ? reg_wr_data : 16'h0;
      // armed_q suppresses edges seen against the zeroed evt_q right after reset
      flags_d = (flags_q & ~((reg_wr_en && reg_wr_addr == 8'h01) ? reg_wr_data : 16'h0))
              | (armed_q ? (evt_i & ~evt_q) : 16'h0);
      mask_d = (reg_wr_en && reg_wr_addr == 8'h02) ? reg_wr_data : mask_q;
      ctrl_d = ctrl_q;
      for (int k = 0; k < NUM_CTRL; k++)
         if (reg_wr_en && reg_wr_addr == 8'(3 + k)) ctrl_d[16*k +: 16] = reg_wr_data;
      wr_cnt_d = clr ? 16'h0 : (reg_wr_en && valid && wr_cnt_q != 16'hFFFF) ? wr_cnt_q + 16'd1 : wr_cnt_q;
      bad_cnt_d = clr ? 16'h0 : (reg_wr_en && !valid && bad_cnt_q != 16'hFFFF) ? bad_cnt_q + 16'd1 : bad_cnt_q;
      last_d = reg_wr_en ? reg_wr_addr : last_q;
      irq_d = |(flags_q & mask_q);
      rd_d = {ctrl_q, 8'h00, last_q, bad_cnt_q, wr_cnt_q, flags_q};
   end
   always_ff @(posedge reg_clk or posedge rst) begin
      if (rst) begin
         cmd_q     <= '0;
         mask_q    <= '0;
         flags_q   <= '0;
         evt_q     <= '0;
         wr_cnt_q  <= '0;
         bad_cnt_q <= '0;
         last_q    <= '0;
         irq_q     <= 1'b0;
         armed_q   <= 1'b0;
         ctrl_q    <= CTRL_RST;
         rd_q      <= {CTRL_RST, 64'h0};
      end else begin
         cmd_q     <= cmd_d;
         mask_q    <= mask_d;
         flags_q   <= flags_d;
         evt_q     <= evt_i;
         wr_cnt_q  <= wr_cnt_d;
         bad_cnt_q <= bad_cnt_d;
         last_q    <= last_d;
         irq_q     <= irq_d;
         armed_q   <= 1'b1;
         ctrl_q    <= ctrl_d;
         rd_q      <= rd_d;
      end
   end
   assign cmd_pulse_o = cmd_q;
   assign ctrl_o      = ctrl_q;
   assign irq_o       = irq_q;
   assign reg_rd_data = rd_q;
endmodule

// File: tb/tb_spi_reg_bank.sv
// tb_spi_reg_bank: directed and random stimulus checked cycle by cycle against
// a behavioural model of the register bank.
module tb_spi_reg_bank;
   localparam int NC = 4;
   localparam int RW = 16*(4+NC);
   localparam logic [16*NC-1:0] CR = 64'h4444_3333_2222_1111;
   logic clk = 0, rst = 0, wr_en = 0;
   logic [7:0] addr = 0;
   logic [15:0] data = 0, evt = 0, cmd;
   logic [RW-1:0] rd;
   logic [16*NC-1:0] ctrl;
   logic irq;
   int n_chk = 0, n_pass = 0;
   logic [15:0] m_ctrl [NC];
   logic [15:0] m_mask, m_flags, m_prev, m_cmd, m_wr, m_bad;
   logic [7:0] m_last;
   logic m_irq, m_armed;
   logic [RW-1:0] m_rd;

   always #5 clk = ~clk;

   spi_reg_bank #(.NUM_CTRL(NC), .CTRL_RST(CR)) dut (
      .reg_clk(clk), .rst(rst), .reg_wr_addr(addr), .reg_wr_data(data), .reg_wr_en(wr_en),
      .reg_rd_data(rd), .evt_i(evt), .cmd_pulse_o(cmd), .ctrl_o(ctrl), .irq_o(irq));

   task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
   endtask

   function automatic logic [16*NC-1:0] m_ctrl_vec();
      logic [16*NC-1:0] v;
      for (int k = 0; k < NC; k++) v[16*k +: 16] = m_ctrl[k];
      return v;
   endfunction

   function automatic logic [RW-1:0] img();
      return {m_ctrl_vec(), 8'h00, m_last, m_bad, m_wr, m_flags};
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < NC; k++) m_ctrl[k] = CR[16*k +: 16];
      {m_mask, m_flags, m_prev, m_cmd, m_wr, m_bad, m_last, m_irq, m_armed} = '0;
      m_rd = img();
   endtask

   task automatic model_step();
      logic [RW-1:0] nrd;
      logic [15:0] rise;
      if (rst) begin
         model_reset();
         return;
      end
      nrd = img();
      m_irq = (m_flags & m_mask) != 0;
      rise = m_armed ? (evt & ~m_prev) : 16'h0;
      m_cmd = 0;
      if (wr_en) begin
         m_last = addr;
         if (addr == 0) begin
            m_cmd = data;
            if (data[15]) begin m_wr = 0; m_bad = 0; end
            else m_wr = sat_inc(m_wr);
         end else if (int'(addr) < 3 + NC) begin
            m_wr = sat_inc(m_wr);
            if (addr == 1) m_flags = m_flags & ~data;
            else if (addr == 2) m_mask = data;
            else m_ctrl[int'(addr) - 3] = data;
         end else m_bad = sat_inc(m_bad);
      end
      m_flags = m_flags | rise;
      m_prev = evt;
      m_armed = 1;
      m_rd = nrd;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".ctrl"}, RW'(ctrl), RW'(m_ctrl_vec()));
      chk({tag, ".cmd"}, RW'(cmd), RW'(m_cmd));
      chk({tag, ".irq"}, RW'(irq), RW'(m_irq));
      chk({tag, ".rd"}, rd, m_rd);
   endtask

   task automatic step(input bit do_chk = 1);
      @(posedge clk);
      model_step();
      @(negedge clk);
      if (do_chk) check_all("model");
   endtask

   task automatic wr(input logic [7:0] a, input logic [15:0] d);
      wr_en = 1; addr = a; data = d;
      step();
      wr_en = 0;
   endtask

   initial begin
      rst = 1;
      step();
      rst = 0;
      step();
      wr(8'h04, 16'hBEEF);
      // reset asserted in the middle of a write
      wr_en = 1; addr = 8'h03; data = 16'hFFFF; rst = 1;
      #1;
      model_reset();
      check_all("async_rst");
      step();
      rst = 0; wr_en = 0;
      step();
      chk("rst_ctrl", RW'(ctrl), RW'(CR));
      chk("rst_rd_lo", RW'(rd[63:0]), '0);
      chk("rst_irq_cmd", RW'({irq, cmd}), '0);
      wr(8'h03, 16'hA5A5);
      wr(8'h06, 16'h1234);
      step();
      chk("ctrl_w0", RW'(ctrl[15:0]), RW'(16'hA5A5));
      chk("ctrl_w3", RW'(ctrl[63:48]), RW'(16'h1234));
      chk("rd_wrcnt", RW'(rd[31:16]), RW'(16'd2));
      chk("rd_last", RW'(rd[63:48]), RW'(16'h0006));
      wr(8'h00, 16'h0081);
      chk("cmd_pulse", RW'(cmd), RW'(16'h0081));
      step();
      chk("cmd_zero", RW'(cmd), '0);
      wr(8'h00, 16'h8000);
      step();
      step();
      chk("clr_cnts", RW'(rd[47:16]), '0);
      wr(8'h02, 16'h0008);
      evt = 16'h0008;
      step();
      step();
      chk("irq_set", RW'(irq), RW'(1'b1));
      evt = 0;
      step();
      evt = 16'h0008;
      wr(8'h01, 16'h0008);
      step();
      chk("set_wins", RW'(rd[3]), RW'(1'b1));
      wr(8'h01, 16'h0008);
      step();
      chk("irq_drop", RW'(irq), '0);
      step();
      chk("flag_clr", RW'(rd[3]), '0);
      wr(8'h40, 16'h5555);
      wr(8'hFF, 16'hAAAA);
      step();
      step();
      chk("bad_cnt2", RW'(rd[47:32]), RW'(16'd2));
      chk("bad_noeff", RW'(ctrl), RW'(64'h1234_3333_2222_A5A5));
      evt = 16'hFFFF; rst = 1;
      step();
      rst = 0;
      step();
      step();
      step();
      chk("evt_held", RW'(rd[15:0]), '0);
      evt = 0;
      step();
      evt = 16'h0001;
      step();
      step();
      chk("evt_fresh", RW'(rd[15:0]), RW'(16'h0001));
      wr_en = 1; addr = 8'h40;
      for (int i = 0; i < 65540; i++) step(0);
      wr_en = 0;
      step();
      step();
      chk("bad_sat", RW'(rd[47:32]), RW'(16'hFFFF));
      for (int i = 0; i < 3000; i++) begin
         wr_en = $urandom_range(1, 0) == 1;
         addr = ($urandom_range(3, 0) == 0) ? 8'($urandom) : 8'($urandom_range(7, 0));
         data = 16'($urandom);
         if (addr == 0 && $urandom_range(7, 0) != 0) data[15] = 0;
         if ($urandom_range(2, 0) == 0) evt = 16'($urandom);
         rst = $urandom_range(499, 0) == 0;
         step();
      end
      rst = 0; wr_en = 0;
      step();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
